// File: rtl/boot_frame_decoder.sv
// Serial bootloader frame parser: checks framed commands and issues flash write/erase requests.
// Optional inter-byte timeout is compiled in with `define BOOT_DECODER_TIMEOUT_EN.
module boot_frame_decoder #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_cmd,
  output logic [23:0] req_addr,
  output logic [31:0] req_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun
);

  localparam int WORDS = MAX_LEN / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_CHECK, S_ISSUE, S_RESP
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [7:0]  r_chk;
  logic [23:0] r_asm;
  logic [31:0] r_mem [WORDS];
  logic [7:0]  r_widx;
  logic        r_req_cmd;
  logic [23:0] r_req_addr;
  logic [31:0] r_req_data;
  logic [7:0]  r_tx_data;
  logic        r_overrun;

  logic        w_write_ok, w_erase_ok, w_ping_ok, w_frame_ok;
  logic        w_last, w_handshake, w_timeout, w_in_frame;
  logic [7:0]  w_resp_byte;
  logic [AW-1:0] w_rd_idx;
  logic        w_req_valid, w_tx_valid, w_busy;

  // Input capture stage: the FSM works on the byte latched at the rx_valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else begin
      r_rx_valid <= rx_valid & enable;
      r_rx_data  <= rx_data;
    end
  end

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CHK);

`ifdef BOOT_DECODER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if (!w_in_frame || r_rx_valid)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = w_in_frame && !r_rx_valid && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_rx_valid && r_rx_data == 8'h5A) w_state_next = S_CMD;
      S_CMD:     if (r_rx_valid) w_state_next = S_ADDR;
      S_ADDR:    if (r_rx_valid && r_cnt == 8'd2) w_state_next = S_LEN;
      S_LEN:     if (r_rx_valid) w_state_next = (r_rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
      S_PAYLOAD: if (r_rx_valid && r_cnt == r_len - 8'd1) w_state_next = S_CHK;
      S_CHK:     if (r_rx_valid) w_state_next = S_CHECK;
      S_CHECK:   w_state_next = (w_frame_ok && !w_ping_ok) ? S_ISSUE : S_RESP;
      S_ISSUE:   if (w_handshake && w_last) w_state_next = S_RESP;
      S_RESP:    if (tx_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_timeout)
      w_state_next = S_RESP;
    if (!enable)
      w_state_next = S_IDLE;
  end

  always_comb begin
    w_write_ok  = (r_cmd == 8'h01) && (r_len != 8'h00) && (r_len[1:0] == 2'b00) &&
                  ({1'b0, r_len} <= MAX_LEN_L) && (r_addr[1:0] == 2'b00);
    w_erase_ok  = (r_cmd == 8'h02) && (r_len == 8'h00) && (r_addr[11:0] == 12'h000);
    w_ping_ok   = (r_cmd == 8'h03) && (r_len == 8'h00);
    // Running XOR including the received checksum byte is zero for an intact frame.
    w_frame_ok  = (r_chk == 8'h00) && (w_write_ok || w_erase_ok || w_ping_ok);
    w_last      = r_req_cmd || (r_widx == {2'b00, r_len[7:2]} - 8'd1);
    w_handshake = (r_state == S_ISSUE) && req_ready;
    w_resp_byte = ((r_state == S_ISSUE) || (r_state == S_CHECK && w_frame_ok && w_ping_ok))
                  ? 8'hAA : 8'h55;
    w_rd_idx    = (r_state == S_CHECK) ? '0 : r_widx[AW-1:0] + AW'(1);
    w_req_valid = (r_state == S_ISSUE);
    w_tx_valid  = (r_state == S_RESP);
    w_busy      = (r_state != S_IDLE);
  end

  // Payload words are assembled big-endian and written once the fourth byte lands.
  always_ff @(posedge clk) begin
    if (r_state == S_PAYLOAD && r_rx_valid && r_cnt[1:0] == 2'b11 && {1'b0, r_cnt} < MAX_LEN_L)
      r_mem[r_cnt[AW+1:2]] <= {r_asm, r_rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= 8'h00;
      r_addr     <= 24'h0;
      r_len      <= 8'h00;
      r_cnt      <= 8'h00;
      r_chk      <= 8'h00;
      r_asm      <= 24'h0;
      r_widx     <= 8'h00;
      r_req_cmd  <= 1'b0;
      r_req_addr <= 24'h0;
      r_req_data <= 32'h0;
      r_tx_data  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      if (!enable)
        r_overrun <= 1'b0;
      else if (r_rx_valid && (r_state == S_ISSUE || r_state == S_RESP))
        r_overrun <= 1'b1;

      case (r_state)
        S_CMD: if (r_rx_valid) begin
          r_cmd <= r_rx_data;
          r_chk <= r_rx_data;
          r_cnt <= 8'h00;
        end
        S_ADDR: if (r_rx_valid) begin
          r_addr <= {r_addr[15:0], r_rx_data};
          r_chk  <= r_chk ^ r_rx_data;
          r_cnt  <= r_cnt + 8'd1;
        end
        S_LEN: if (r_rx_valid) begin
          r_len <= r_rx_data;
          r_chk <= r_chk ^ r_rx_data;
          r_cnt <= 8'h00;
        end
        S_PAYLOAD: if (r_rx_valid) begin
          r_chk <= r_chk ^ r_rx_data;
          r_cnt <= r_cnt + 8'd1;
          r_asm <= {r_asm[15:0], r_rx_data};
        end
        S_CHK: if (r_rx_valid) r_chk <= r_chk ^ r_rx_data;
        S_CHECK: if (w_state_next == S_ISSUE) begin
          r_req_cmd  <= (r_cmd == 8'h02);
          r_req_addr <= r_addr;
          r_req_data <= (r_cmd == 8'h02) ? 32'h0 : r_mem[w_rd_idx];
          r_widx     <= 8'h00;
        end
        S_ISSUE: if (w_handshake && !w_last) begin
          r_widx     <= r_widx + 8'd1;
          r_req_addr <= r_req_addr + 24'd4;
          r_req_data <= r_mem[w_rd_idx];
        end
        default: ;
      endcase

      if (r_state != S_RESP && w_state_next == S_RESP)
        r_tx_data <= w_resp_byte;
    end
  end

  assign req_valid = w_req_valid;
  assign req_cmd   = r_req_cmd;
  assign req_addr  = r_req_addr;
  assign req_data  = r_req_data;
  assign tx_data   = r_tx_data;
  assign tx_valid  = w_tx_valid;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule
